// File: rtl/multi_lane_phase_align_pkg.sv
// Shared definitions for the multi-lane capture phase aligner: controller states,
// datapath reset / clock-stop pulse lengths and a width helper.
package multi_lane_phase_align_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_SWEEP      = 4'd1,
        ST_EVAL       = 4'd2,
        ST_APPLY      = 4'd3,
        ST_NEXT_LANE  = 4'd4,
        ST_RST_DP     = 4'd5,
        ST_CHECK_WORD = 4'd6,
        ST_GOOD       = 4'd7,
        ST_ERR        = 4'd8
    } state_e;

    localparam int RST_DP_PULSE_LEN = 8;
    localparam int STOP_PULSE_LEN   = 12;

    // Bits needed to index n items, never less than one.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/multi_lane_phase_align_window_tracker.sv
// Tracks the current and longest run of passing phases during a sweep and
// derives the centre phase of the longest (earliest on ties) window.
module window_tracker #(
    parameter int PHASE_W = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               eval_i,
    input  logic               pass_i,
    input  logic [PHASE_W-1:0] phase_i,
    output logic [PHASE_W:0]   run_nxt_o,
    output logic [PHASE_W:0]   best_len_nxt_o,
    output logic [PHASE_W-1:0] center_o
);

    localparam logic [PHASE_W:0] RUN_SAT = (PHASE_W + 1)'(1) << PHASE_W;

    logic [PHASE_W:0]   run_q, run_d, best_len_q, best_len_d;
    logic [PHASE_W:0]   run_prev, start_full, half;
    logic [PHASE_W-1:0] best_start_q, best_start_d;

    always_comb begin
        // Windows never wrap: phase 0 always starts a fresh run.
        run_prev     = (phase_i == '0) ? '0 : run_q;
        run_nxt_o    = !pass_i ? '0 : ((run_prev == RUN_SAT) ? run_prev : run_prev + 1'b1);
        start_full   = {1'b0, phase_i} - run_nxt_o + 1'b1;
        run_d        = run_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        if (clear_i) begin
            run_d        = '0;
            best_len_d   = '0;
            best_start_d = '0;
        end else if (eval_i) begin
            run_d = run_nxt_o;
            if (run_nxt_o > best_len_q) begin
                best_len_d   = run_nxt_o;
                best_start_d = start_full[PHASE_W-1:0];
            end
        end
    end

    assign best_len_nxt_o = (run_nxt_o > best_len_q) ? run_nxt_o : best_len_q;
    assign half           = (best_len_q - 1'b1) >> 1;
    assign center_o       = best_start_q + half[PHASE_W-1:0];

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            run_q        <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
        end else begin
            run_q        <= run_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
        end
    end

endmodule

// File: rtl/multi_lane_phase_align.sv
// Per-lane capture phase training: sweep every phase, pick the passing window,
// then pulse a datapath reset until word alignment holds, and monitor in GOOD.
module multi_lane_phase_align
    import multi_lane_phase_align_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int PHASE_W     = 4,
    parameter int TMR_W       = 8,
    parameter int RTY_W       = 8,
    parameter int MARGIN      = 6,
    parameter int CENTER_MODE = 1,
    localparam int LW         = clog2_min1(LANES)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     lock_i,
    input  logic [2*LANES-1:0]       align_status_i,
    input  logic                     reset_datapath_i,
    output logic [LANES*PHASE_W-1:0] phase_o,
    output logic                     reset_datapath_out_o,
    output logic                     stop_out_o,
    output logic                     good_o,
    output logic                     good_int_o,
    output logic                     err_o,
    output logic [LW-1:0]            cur_lane_o
);

    localparam logic [TMR_W-1:0]   TMR_MAX  = '1;
    localparam logic [TMR_W-1:0]   TMR_END  = TMR_MAX - 1'b1;
    localparam logic [TMR_W-1:0]   RDP_END  = TMR_W'(RST_DP_PULSE_LEN);
    localparam logic [TMR_W-1:0]   STOP_END = TMR_W'(STOP_PULSE_LEN);
    localparam logic [RTY_W-1:0]   RTY_MAX  = '1;
    localparam logic [RTY_W-1:0]   RTY_LAST = RTY_MAX - 1'b1;
    localparam logic [PHASE_W-1:0] PH_LAST  = '1;
    localparam logic [PHASE_W:0]   MARGIN_V = (PHASE_W + 1)'(MARGIN);
    localparam logic [LW-1:0]      LANE_LAST = LW'(LANES - 1);

    state_e                         state_q, state_d;
    logic                           lock_q, rdp_ff_q, fail_q, fail_d;
    logic [2*LANES-1:0]             status_q;
    logic [TMR_W-1:0]               timer_q, timer_d;
    logic [RTY_W-1:0]               retry_q, retry_d;
    logic [LW-1:0]                  lane_q, lane_d;
    logic [LANES-1:0][PHASE_W-1:0]  phase_q, phase_d;
    logic                           rdp_out_q, rdp_out_d, stop_out_q, stop_out_d;
    logic                           good_int_q, good_int_d, gint_done_q, gint_done_d;
    logic                           bit_any, word_any, trk_clear;
    logic [PHASE_W-1:0]             cur_phase, center;
    logic [PHASE_W:0]               run_nxt, best_len_nxt;

    assign cur_phase = phase_q[lane_q];

    always_comb begin
        bit_any  = 1'b0;
        word_any = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            bit_any  = bit_any  | status_q[2*i];
            word_any = word_any | status_q[2*i+1];
        end
    end

    window_tracker #(.PHASE_W(PHASE_W)) u_tracker (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .clear_i        (trk_clear),
        .eval_i         (state_q == ST_EVAL),
        .pass_i         (!fail_q),
        .phase_i        (cur_phase),
        .run_nxt_o      (run_nxt),
        .best_len_nxt_o (best_len_nxt),
        .center_o       (center)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (lock_q) state_d = ST_SWEEP;
            ST_SWEEP:      if (lock_q && timer_q == TMR_MAX) state_d = ST_EVAL;
            ST_EVAL: begin
                if (CENTER_MODE == 0 && run_nxt >= MARGIN_V) state_d = ST_APPLY;
                else if (cur_phase != PH_LAST)               state_d = ST_SWEEP;
                else if (best_len_nxt >= MARGIN_V)           state_d = ST_APPLY;
                else if (retry_q == RTY_LAST)                state_d = ST_ERR;
                else                                         state_d = ST_SWEEP;
            end
            ST_APPLY:      state_d = ST_NEXT_LANE;
            ST_NEXT_LANE:  state_d = (lane_q < LANE_LAST) ? ST_SWEEP : ST_RST_DP;
            ST_RST_DP:     if (timer_q == TMR_END) state_d = (retry_q == RTY_MAX) ? ST_ERR : ST_CHECK_WORD;
            ST_CHECK_WORD: state_d = word_any ? ST_RST_DP : ST_GOOD;
            ST_GOOD: begin
                // Monitoring is suspended while the PLL is unlocked.
                if (lock_q) begin
                    if (bit_any)                    state_d = ST_IDLE;
                    else if (word_any || rdp_ff_q)  state_d = ST_RST_DP;
                end
            end
            ST_ERR:        if (rdp_ff_q) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        timer_d   = timer_q;
        retry_d   = retry_q;
        lane_d    = lane_q;
        phase_d   = phase_q;
        fail_d    = fail_q;
        trk_clear = 1'b0;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if ((state_q == ST_SWEEP && lock_q) || state_q == ST_RST_DP || state_q == ST_GOOD) begin
            if (timer_q != TMR_MAX) timer_d = timer_q + 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                retry_d = '0;
                if (lock_q) begin
                    lane_d     = '0;
                    phase_d[0] = '0;
                    trk_clear  = 1'b1;
                end
            end
            ST_SWEEP: if (state_d == ST_EVAL) fail_d = status_q[{lane_q, 1'b0}];
            ST_EVAL: begin
                if (state_d == ST_SWEEP && cur_phase != PH_LAST) begin
                    phase_d[lane_q] = cur_phase + 1'b1;
                end else if (cur_phase == PH_LAST && state_d != ST_APPLY) begin
                    retry_d = retry_q + 1'b1;
                    if (state_d == ST_SWEEP) begin
                        phase_d[lane_q] = '0;
                        trk_clear       = 1'b1;
                    end
                end
            end
            ST_APPLY:      if (CENTER_MODE != 0) phase_d[lane_q] = center;
            ST_NEXT_LANE: begin
                retry_d = '0;
                if (state_d == ST_SWEEP) begin
                    lane_d          = lane_q + 1'b1;
                    phase_d[lane_d] = '0;
                    trk_clear       = 1'b1;
                end
            end
            ST_CHECK_WORD: if (state_d == ST_GOOD) retry_d = '0;
            default: ;
        endcase
        // Each pass through the datapath reset counts as one retry.
        if (state_d == ST_RST_DP && state_q != ST_RST_DP && retry_d != RTY_MAX) retry_d = retry_d + 1'b1;
    end

    always_comb begin
        rdp_out_d   = (state_q == ST_RST_DP) && (timer_q < RDP_END);
        stop_out_d  = (state_q == ST_RST_DP) && (timer_q < STOP_END);
        good_int_d  = (state_q == ST_GOOD) && (timer_q == TMR_MAX) && !gint_done_q;
        gint_done_d = (state_q == ST_GOOD) && (gint_done_q || good_int_d);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lock_q      <= 1'b0;
            rdp_ff_q    <= 1'b0;
            status_q    <= '0;
            fail_q      <= 1'b0;
            timer_q     <= '0;
            retry_q     <= '0;
            lane_q      <= '0;
            phase_q     <= '0;
            rdp_out_q   <= 1'b0;
            stop_out_q  <= 1'b0;
            good_int_q  <= 1'b0;
            gint_done_q <= 1'b0;
        end else begin
            lock_q      <= lock_i;
            rdp_ff_q    <= reset_datapath_i;
            if (lock_q) status_q <= align_status_i;
            fail_q      <= fail_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            lane_q      <= lane_d;
            phase_q     <= phase_d;
            rdp_out_q   <= rdp_out_d;
            stop_out_q  <= stop_out_d;
            good_int_q  <= good_int_d;
            gint_done_q <= gint_done_d;
        end
    end

    assign phase_o              = phase_q;
    assign reset_datapath_out_o = rdp_out_q;
    assign stop_out_o           = stop_out_q;
    assign good_o               = (state_q == ST_GOOD);
    assign good_int_o           = good_int_q;
    assign err_o                = (state_q == ST_ERR);
    assign cur_lane_o           = lane_q;

endmodule

// File: tb/tb_multi_lane_phase_align.sv
// Directed bench for the phase aligner: a centre-mode instance (a) with short
// timers and a 2-bit retry counter, and a first-pass instance (b).
module tb_multi_lane_phase_align;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n_a, lock_a, rdp_a;
    logic [3:0] status_a;
    logic [7:0] phase_a;
    logic       rdp_out_a, stop_a, good_a, gint_a, err_a;
    logic [0:0] lane_a;

    logic       reset_n_b, lock_b, rdp_b;
    logic [3:0] status_b;
    logic [7:0] phase_b;
    logic       rdp_out_b, stop_b, good_b, gint_b, err_b;
    logic [0:0] lane_b;

    logic all_fail_a, force_bit_a, force_word_a;
    int   total = 0;
    int   bad   = 0;

    multi_lane_phase_align #(.LANES(2), .PHASE_W(4), .TMR_W(4), .RTY_W(2), .MARGIN(6), .CENTER_MODE(1)) dut_a (
        .clk(clk), .reset_n(reset_n_a), .lock_i(lock_a), .align_status_i(status_a),
        .reset_datapath_i(rdp_a), .phase_o(phase_a), .reset_datapath_out_o(rdp_out_a),
        .stop_out_o(stop_a), .good_o(good_a), .good_int_o(gint_a), .err_o(err_a), .cur_lane_o(lane_a)
    );

    multi_lane_phase_align #(.LANES(2), .PHASE_W(4), .TMR_W(4), .RTY_W(2), .MARGIN(6), .CENTER_MODE(0)) dut_b (
        .clk(clk), .reset_n(reset_n_b), .lock_i(lock_b), .align_status_i(status_b),
        .reset_datapath_i(rdp_b), .phase_o(phase_b), .reset_datapath_out_o(rdp_out_b),
        .stop_out_o(stop_b), .good_o(good_b), .good_int_o(gint_b), .err_o(err_b), .cur_lane_o(lane_b)
    );

    function automatic logic in_win(logic [3:0] ph, int lo, int hi);
        return (int'(ph) >= lo) && (int'(ph) <= hi);
    endfunction

    // Channel model: each lane passes only inside its window of phases.
    always_comb begin
        status_a[0] = all_fail_a | force_bit_a | !in_win(phase_a[3:0], 3, 10);
        status_a[1] = force_word_a;
        status_a[2] = all_fail_a | force_bit_a | !in_win(phase_a[7:4], 9, 14);
        status_a[3] = force_word_a;
        status_b[0] = !in_win(phase_b[3:0], 2, 12);
        status_b[1] = 1'b0;
        status_b[2] = !in_win(phase_b[7:4], 4, 15);
        status_b[3] = 1'b0;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n_a = 1'b0; lock_a = 1'b0; rdp_a = 1'b0;
        repeat (3) tick();
        lock_a = 1'b1;
        tick();
        total++; if (phase_a !== 8'h00) begin bad++; $display("FAIL reset_phase: got %h expected 00", phase_a); end
        total++; if (rdp_out_a !== 1'b0) begin bad++; $display("FAIL reset_rdp_out: got %b expected 0", rdp_out_a); end
        total++; if (stop_a !== 1'b0) begin bad++; $display("FAIL reset_stop: got %b expected 0", stop_a); end
        total++; if (good_a !== 1'b0) begin bad++; $display("FAIL reset_good: got %b expected 0", good_a); end
        total++; if (gint_a !== 1'b0) begin bad++; $display("FAIL reset_good_int: got %b expected 0", gint_a); end
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", err_a); end
        total++; if (lane_a !== 1'b0) begin bad++; $display("FAIL reset_cur_lane: got %b expected 0", lane_a); end
    endtask

    task automatic test_two_lane_sweep();
        int   n = 0;
        int   rises = 0;
        logic prev = 1'b0;
        reset_n_a = 1'b1;
        while (!good_a && n < 3000) begin
            tick(); n++;
            if (rdp_out_a && !prev) rises++;
            prev = rdp_out_a;
        end
        total++; if (good_a !== 1'b1) begin bad++; $display("FAIL sweep_good_timeout: got %b expected 1", good_a); end
        total++; if (phase_a !== 8'hB6) begin bad++; $display("FAIL sweep_phase: got %h expected b6", phase_a); end
        total++; if (rises !== 1) begin bad++; $display("FAIL sweep_rst_dp_count: got %0d expected 1", rises); end
        total++; if (lane_a !== 1'b1) begin bad++; $display("FAIL sweep_cur_lane: got %b expected 1", lane_a); end
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL sweep_err: got %b expected 0", err_a); end
        n = 0;
        while (!gint_a && n < 100) begin tick(); n++; end
        total++; if (n !== 16) begin bad++; $display("FAIL good_int_delay: got %0d expected 16", n); end
        tick();
        total++; if (gint_a !== 1'b0) begin bad++; $display("FAIL good_int_width: got %b expected 0", gint_a); end
    endtask

    task automatic test_word_fail();
        int   rdp_cnt = 0;
        int   stop_cnt = 0;
        logic saw_low = 1'b0;
        force_word_a = 1'b1;
        tick();
        force_word_a = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (rdp_out_a) rdp_cnt++;
            if (stop_a) stop_cnt++;
            if (!good_a) saw_low = 1'b1;
        end
        total++; if (rdp_cnt !== 8) begin bad++; $display("FAIL word_rdp_len: got %0d expected 8", rdp_cnt); end
        total++; if (stop_cnt !== 12) begin bad++; $display("FAIL word_stop_len: got %0d expected 12", stop_cnt); end
        total++; if (saw_low !== 1'b1) begin bad++; $display("FAIL word_left_good: got %b expected 1", saw_low); end
        total++; if (good_a !== 1'b1) begin bad++; $display("FAIL word_back_good: got %b expected 1", good_a); end
    endtask

    task automatic test_retrain_lock_drop();
        int n = 0;
        int c = 0;
        int moved = 0;
        force_bit_a = 1'b1;
        tick();
        force_bit_a = 1'b0;
        tick(); tick();
        total++; if (good_a !== 1'b0) begin bad++; $display("FAIL retrain_good: got %b expected 0", good_a); end
        total++; if (phase_a !== 8'hB0) begin bad++; $display("FAIL retrain_phase: got %h expected b0", phase_a); end
        while (phase_a[3:0] != 4'd2 && n < 200) begin tick(); n++; end
        repeat (5) begin tick(); c++; end
        lock_a = 1'b0;
        repeat (20) begin
            tick(); c++;
            if (phase_a[3:0] != 4'd2) moved++;
        end
        lock_a = 1'b1;
        while (phase_a[3:0] == 4'd2 && c < 200) begin tick(); c++; end
        total++; if (moved !== 0) begin bad++; $display("FAIL lockdrop_frozen: got %0d expected 0", moved); end
        total++; if (c !== 37) begin bad++; $display("FAIL lockdrop_period: got %0d expected 37", c); end
        total++; if (phase_a[3:0] !== 4'd3) begin bad++; $display("FAIL lockdrop_resume: got %0d expected 3", phase_a[3:0]); end
        n = 0;
        while (!good_a && n < 2000) begin tick(); n++; end
        total++; if (phase_a !== 8'hB6) begin bad++; $display("FAIL retrain_final_phase: got %h expected b6", phase_a); end
    endtask

    task automatic test_reset_mid_rst_dp();
        int n = 0;
        int late = 0;
        rdp_a = 1'b1;
        tick();
        rdp_a = 1'b0;
        while (!rdp_out_a && n < 20) begin tick(); n++; end
        total++; if (rdp_out_a !== 1'b1) begin bad++; $display("FAIL request_rdp_out: got %b expected 1", rdp_out_a); end
        tick(); tick();
        reset_n_a = 1'b0;
        tick();
        total++; if (rdp_out_a !== 1'b0) begin bad++; $display("FAIL abort_rdp_out: got %b expected 0", rdp_out_a); end
        total++; if (stop_a !== 1'b0) begin bad++; $display("FAIL abort_stop: got %b expected 0", stop_a); end
        total++; if (good_a !== 1'b0) begin bad++; $display("FAIL abort_good: got %b expected 0", good_a); end
        total++; if (phase_a !== 8'h00) begin bad++; $display("FAIL abort_phase: got %h expected 00", phase_a); end
        repeat (3) begin
            tick();
            if (rdp_out_a || stop_a || gint_a || err_a) late++;
        end
        total++; if (late !== 0) begin bad++; $display("FAIL abort_residual: got %0d expected 0", late); end
        reset_n_a = 1'b1;
    endtask

    task automatic test_retry_err();
        int         n = 0;
        int         wraps = 0;
        int         err_drop = 0;
        logic [3:0] prev;
        reset_n_a = 1'b0; all_fail_a = 1'b1;
        tick(); tick();
        reset_n_a = 1'b1;
        prev = phase_a[3:0];
        while (!err_a && n < 3000) begin
            tick(); n++;
            if (prev == 4'd15 && phase_a[3:0] == 4'd0) wraps++;
            prev = phase_a[3:0];
        end
        total++; if (err_a !== 1'b1) begin bad++; $display("FAIL retry_err: got %b expected 1", err_a); end
        total++; if (wraps !== 2) begin bad++; $display("FAIL retry_restarts: got %0d expected 2", wraps); end
        total++; if (phase_a[3:0] !== 4'd15) begin bad++; $display("FAIL retry_last_phase: got %0d expected 15", phase_a[3:0]); end
        repeat (10) begin tick(); if (!err_a) err_drop++; end
        total++; if (err_drop !== 0) begin bad++; $display("FAIL err_hold: got %0d expected 0", err_drop); end
        rdp_a = 1'b1;
        tick();
        rdp_a = 1'b0;
        tick(); tick();
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL err_exit: got %b expected 0", err_a); end
        total++; if (phase_a[3:0] !== 4'd0) begin bad++; $display("FAIL err_exit_phase: got %0d expected 0", phase_a[3:0]); end
        all_fail_a = 1'b0;
    endtask

    task automatic test_first_pass_mode();
        int         n = 0;
        logic [3:0] max_ph = 4'd0;
        reset_n_b = 1'b1;
        while (!good_b && n < 3000) begin
            tick(); n++;
            if (lane_b == 1'b0 && phase_b[3:0] > max_ph) max_ph = phase_b[3:0];
        end
        total++; if (good_b !== 1'b1) begin bad++; $display("FAIL first_good_timeout: got %b expected 1", good_b); end
        total++; if (phase_b[3:0] !== 4'd7) begin bad++; $display("FAIL first_lane0_phase: got %0d expected 7", phase_b[3:0]); end
        total++; if (max_ph !== 4'd7) begin bad++; $display("FAIL first_lane0_max: got %0d expected 7", max_ph); end
        total++; if (phase_b[7:4] !== 4'd9) begin bad++; $display("FAIL first_lane1_phase: got %0d expected 9", phase_b[7:4]); end
    endtask

    initial begin
        reset_n_a = 1'b0; lock_a = 1'b0; rdp_a = 1'b0;
        reset_n_b = 1'b0; lock_b = 1'b1; rdp_b = 1'b0;
        all_fail_a = 1'b0; force_bit_a = 1'b0; force_word_a = 1'b0;
        test_reset();
        test_two_lane_sweep();
        test_word_fail();
        test_retrain_lock_drop();
        test_reset_mid_rst_dp();
        test_retry_err();
        test_first_pass_mode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_lane_phase_align.md
MULTI_LANE_PHASE_ALIGN -- requirements
Module: multi_lane_phase_align

Interface
REQ-001 SHALL have parameter LANES, default 2, number of independently trained capture lanes.
REQ-002 SHALL have parameter PHASE_W, default 4, phase-select width; the sweep covers 2^PHASE_W steps.
REQ-003 SHALL have parameter TMR_W, default 8, settle-timer width; TMR_MAX = 2^TMR_W-1.
REQ-004 SHALL have parameter RTY_W, default 8, retry-counter width; RTY_MAX = 2^RTY_W-1.
REQ-005 SHALL have parameter MARGIN, default 6, the minimum count of consecutive passing phases for a valid window.
REQ-006 SHALL have parameter CENTER_MODE, default 1; 1 = full sweep then centre, 0 = stop at the first phase completing MARGIN passes.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-008 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-009 SHALL have port lock, input, 1, PLL lock; registered once internally before any use.
REQ-010 SHALL have port align_status, input, 2*LANES, with bit 2i = lane i bit-fail and bit 2i+1 = lane i word-fail; 0 = good.
REQ-011 SHALL have port reset_datapath, input, 1, retrain/realign request; registered once internally.
REQ-012 SHALL have port phase, output, LANES*PHASE_W, with lane i's phase select at bits [i*PHASE_W +: PHASE_W].
REQ-013 SHALL have port reset_datapath_out, output, 1, the registered datapath reset.
REQ-014 SHALL have port stop_out, output, 1, the registered clock-stop strobe.
REQ-015 SHALL have port good, output, 1, asserted while in GOOD.
REQ-016 SHALL have port good_int, output, 1, a one-cycle pulse on each GOOD entry after the settle time.
REQ-017 SHALL have port err, output, 1, asserted while in ERR.
REQ-018 SHALL have port cur_lane, output, clog2(LANES) (minimum 1), the lane under training.

Function
REQ-019 SHALL implement states IDLE, SWEEP, EVAL, APPLY, NEXT_LANE, RST_DP, CHECK_WORD, GOOD and ERR.
REQ-020 SHALL sample align_status into a register only while lock_reg = 1; the register SHALL hold otherwise.
REQ-021 IDLE: lock_reg = 1 -> SWEEP with cur_lane = 0, the lane's phase = 0, run/best trackers cleared, and the timer cleared.
REQ-022 SWEEP: the timer SHALL count up saturating at TMR_MAX and freeze while lock_reg = 0; on timer = TMR_MAX with lock_reg = 1 the state SHALL sample lane bit-fail -> EVAL.
REQ-023 EVAL, on a pass: run_len++ (saturating at 2^PHASE_W); on a fail: run_len = 0; best_start/best_len SHALL update when run_len > best_len (strict, so the earliest window wins ties).
REQ-024 EVAL, CENTER_MODE = 0: run_len reaching MARGIN -> APPLY holding the current phase.
REQ-025 EVAL, when the phase is not the last: phase++ -> SWEEP with the timer cleared.
REQ-026 EVAL, on the last phase (2^PHASE_W-1): best_len >= MARGIN -> APPLY; otherwise retry_cnt++ and the sweep restarts at phase 0; retry_cnt = RTY_MAX -> ERR.
REQ-027 Windows SHALL NOT wrap; run_len SHALL be cleared at phase 0 of each sweep.
REQ-028 APPLY, CENTER_MODE = 1: phase = best_start + (best_len-1)/2, truncated, mod 2^PHASE_W; the state SHALL then advance to NEXT_LANE.
REQ-029 NEXT_LANE: clear retry_cnt; if cur_lane < LANES-1 then cur_lane++ -> SWEEP, else -> RST_DP.
REQ-030 Phases of lanes other than cur_lane SHALL hold their value throughout.
REQ-031 RST_DP: reset_datapath_out SHALL be high for timer 0..7 and stop_out high for timer 0..11, each registered one cycle.
REQ-032 RST_DP: at timer = TMR_MAX-1 -> CHECK_WORD; retry_cnt SHALL increment once per RST_DP entry; retry_cnt = RTY_MAX -> ERR.
REQ-033 CHECK_WORD: all word-fail bits 0 -> GOOD with retry_cnt cleared; otherwise -> RST_DP.
REQ-034 GOOD: lock_reg = 0 -> stay (monitoring suspended).
REQ-035 GOOD, lock_reg = 1: any bit-fail -> IDLE (full retrain); else any word-fail or reset_datapath_ff -> RST_DP; bit-fail SHALL take priority.
REQ-036 GOOD: the timer SHALL run saturating; good_int SHALL pulse one cycle on the cycle after the timer first reaches TMR_MAX.
REQ-037 ERR: reset_datapath_ff = 1 -> IDLE; otherwise the state SHALL hold.
REQ-038 Unreachable state encodings SHALL return to IDLE.

Reset
REQ-039 reset_n = 0 at a clk edge: state = IDLE; all phases, timer, retry_cnt, trackers, cur_lane, lock_reg and the status registers SHALL be 0; all outputs SHALL be 0 on the following cycle.
REQ-040 A reset asserted mid-sweep or mid-RST_DP SHALL abort immediately, with no residual reset_datapath_out or stop_out pulse.

Structure
REQ-041 A shared package SHALL hold the state enum, the RST_DP pulse lengths (8 and 12) and the clog2 helper.
REQ-042 A sub-module window_tracker SHALL contain run_len/best_start/best_len and the centre computation, parametrised by PHASE_W.

Verification
REQ-043 LANES = 2, PHASE_W = 4: lane 0 passes phases 3..10, lane 1 passes 9..14 -> phase = {lane1 = 11, lane0 = 6}, then one RST_DP and GOOD.
REQ-044 CENTER_MODE = 0, lane 0 passes 2..12 -> lane 0 locks at phase 7 without sweeping further.
REQ-045 Bit-fail always high with RTY_W = 2 -> exactly 3 full sweeps, then err = 1; reset_datapath pulse -> returns to IDLE.
REQ-046 In GOOD, word-fail forced high for 1 cycle -> RST_DP: reset_datapath_out high 8 cycles, stop_out high 12 cycles, then GOOD.
REQ-047 Drop lock mid-SWEEP for 20 cycles -> timer and phase frozen, sweep resumes unchanged.
REQ-048 Assert reset_n = 0 during RST_DP at timer = 3 -> all outputs 0 on the next cycle, state IDLE.
